// File: rtl/linebuffer_pkg.sv
// Shared types and constants for the double-buffered sprite line buffer.
// Holds the read FSM state type, default geometry, the transparent colour
// index and a helper that packs {palette, index} at the default widths.
package linebuffer_pkg;

    localparam int DEF_DEPTH = 320;
    localparam int DEF_AW    = 9;
    localparam int DEF_IDX_W = 4;
    localparam int DEF_PAL_W = 8;

    // Colour index that means "no pixel here"; such writes leave the RAM alone.
    localparam int TRANSPARENT_IDX = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    function automatic logic [DEF_PAL_W+DEF_IDX_W-1:0] pack_pixel(
        input logic [DEF_PAL_W-1:0] pal,
        input logic [DEF_IDX_W-1:0] idx
    );
        return {pal, idx};
    endfunction

endpackage

// File: rtl/lb_bank_ram.sv
// One line-buffer bank: DEPTH words, one write port and one synchronous read
// port. A read and a write to the same address in one cycle return the old
// word, which is what lets the streamer clear each pixel right behind itself.
module lb_bank_ram #(
    parameter int DEPTH = 320,
    parameter int AW    = 9,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage array; contents survive reset, only the caller gates addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value while no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/linebuffer_pair.sv
// Double-buffered sprite line buffer: one bank is rendered into while the
// other is streamed out and cleared to BACKDROP behind the read.
// Optional build macro LINEBUFFER_OVF_FLAG_EN adds a sticky OVF output that
// flags opaque writes beyond the end of the line.
module linebuffer_pair
    import linebuffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int IDX_W = DEF_IDX_W,
    parameter int PAL_W = DEF_PAL_W,
    parameter logic [IDX_W+PAL_W-1:0] BACKDROP = {(IDX_W+PAL_W){1'b1}}
) (
    input  logic                   CK,
    input  logic                   nRESET,
    input  logic                   FLIP,
    input  logic                   LOAD,
    input  logic [AW-1:0]          ADDR_LOAD,
    input  logic [PAL_W-1:0]       SPR_PAL,
    input  logic                   WE,
    input  logic [IDX_W-1:0]       COLOR_INDEX,
    input  logic                   RD_START,
    output logic [IDX_W+PAL_W-1:0] DATA_OUT,
    output logic                   RD_VALID,
    output logic                   RENDER_BANK,
    output logic                   BUSY
`ifdef LINEBUFFER_OVF_FLAG_EN
    ,
    output logic                   OVF
`endif
);

    localparam int DW = IDX_W + PAL_W;
    localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic             render_bank;
    logic [AW-1:0]    render_addr;
    logic [PAL_W-1:0] pal_latch;

    rd_state_t        state;
    rd_state_t        state_next;
    logic [AW-1:0]    rd_addr;
    logic             rd_sel;
    logic             rd_valid;
    logic             busy;

    logic             pixel_opaque;
    logic             in_range;
    logic             render_we;
    logic             stream_issue;
    logic             last_issue;
    logic [DW-1:0]    render_data;

    logic             we_a, we_b, re_a, re_b;
    logic [AW-1:0]    waddr_a, waddr_b;
    logic [DW-1:0]    wdata_a, wdata_b, rdata_a, rdata_b;

    assign pixel_opaque = (COLOR_INDEX != IDX_W'(TRANSPARENT_IDX));
    assign in_range     = ({1'b0, render_addr} < DEPTH_X);
    assign render_we    = nRESET && WE && !LOAD && pixel_opaque && in_range;
    assign stream_issue = nRESET && (state == STREAM);
    assign last_issue   = (state == STREAM) && (rd_addr == LAST_ADDR);
    assign render_data  = {pal_latch, COLOR_INDEX};

    // Render side: bank selection, strip start address and palette latch.
    always_ff @(posedge CK) begin
        if (!nRESET) begin
            render_bank <= 1'b0;
            render_addr <= '0;
            pal_latch   <= '0;
        end else begin
            if (FLIP) begin
                render_bank <= ~render_bank;
            end
            if (LOAD) begin
                render_addr <= ADDR_LOAD;
                pal_latch   <= SPR_PAL;
            end else if (WE) begin
                render_addr <= render_addr + AW'(1);
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge CK) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state: a FLIP aborts, otherwise run until the last address.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (RD_START) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (FLIP || (rd_addr == LAST_ADDR)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read address, output bank select, valid and busy tracking.
    always_ff @(posedge CK) begin
        if (!nRESET) begin
            rd_addr  <= '0;
            rd_sel   <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rd_valid <= stream_issue;
            busy     <= (state_next == STREAM) || (last_issue && !FLIP);
            if (stream_issue) begin
                rd_sel  <= ~render_bank;
                rd_addr <= rd_addr + AW'(1);
            end else if (RD_START) begin
                rd_addr <= '0;
            end
        end
    end

    assign we_a    = render_bank ? stream_issue : render_we;
    assign waddr_a = render_bank ? rd_addr      : render_addr;
    assign wdata_a = render_bank ? BACKDROP     : render_data;
    assign re_a    = render_bank && stream_issue;

    assign we_b    = render_bank ? render_we    : stream_issue;
    assign waddr_b = render_bank ? render_addr  : rd_addr;
    assign wdata_b = render_bank ? render_data  : BACKDROP;
    assign re_b    = !render_bank && stream_issue;

    lb_bank_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_bank_a (
        .clk   (CK),
        .rst_n (nRESET),
        .we    (we_a),
        .waddr (waddr_a),
        .wdata (wdata_a),
        .re    (re_a),
        .raddr (rd_addr),
        .rdata (rdata_a)
    );

    lb_bank_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_bank_b (
        .clk   (CK),
        .rst_n (nRESET),
        .we    (we_b),
        .waddr (waddr_b),
        .wdata (wdata_b),
        .re    (re_b),
        .raddr (rd_addr),
        .rdata (rdata_b)
    );

    assign DATA_OUT    = rd_sel ? rdata_b : rdata_a;
    assign RD_VALID    = rd_valid;
    assign RENDER_BANK = render_bank;
    assign BUSY        = busy;

`ifdef LINEBUFFER_OVF_FLAG_EN
    logic ovf;

    // Sticky overflow: opaque write past the line end; a set beats a FLIP clear.
    always_ff @(posedge CK) begin
        if (!nRESET) begin
            ovf <= 1'b0;
        end else if (WE && !LOAD && pixel_opaque && !in_range) begin
            ovf <= 1'b1;
        end else if (FLIP) begin
            ovf <= 1'b0;
        end
    end

    assign OVF = ovf;
`endif

endmodule

// File: tb/tb_linebuffer_pair.sv
// Testbench for linebuffer_pair: directed render/stream sequences with a
// queue of expected pixels drained by an independent output monitor.
module tb_linebuffer_pair;
    import linebuffer_pkg::*;

    localparam int DEPTH = 320;

    logic        CK = 1'b0;
    logic        nRESET = 1'b0;
    logic        FLIP = 1'b0;
    logic        LOAD = 1'b0;
    logic [8:0]  ADDR_LOAD = '0;
    logic [7:0]  SPR_PAL = '0;
    logic        WE = 1'b0;
    logic [3:0]  COLOR_INDEX = '0;
    logic        RD_START = 1'b0;
    logic [11:0] DATA_OUT;
    logic        RD_VALID;
    logic        RENDER_BANK;
    logic        BUSY;
`ifdef LINEBUFFER_OVF_FLAG_EN
    logic        OVF;
`endif

    linebuffer_pair dut (
        .CK          (CK),
        .nRESET      (nRESET),
        .FLIP        (FLIP),
        .LOAD        (LOAD),
        .ADDR_LOAD   (ADDR_LOAD),
        .SPR_PAL     (SPR_PAL),
        .WE          (WE),
        .COLOR_INDEX (COLOR_INDEX),
        .RD_START    (RD_START),
        .DATA_OUT    (DATA_OUT),
        .RD_VALID    (RD_VALID),
        .RENDER_BANK (RENDER_BANK),
        .BUSY        (BUSY)
`ifdef LINEBUFFER_OVF_FLAG_EN
        ,
        .OVF         (OVF)
`endif
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic        chk;
        logic [11:0] data;
        logic [8:0]  pix;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [11:0] mdl [2][DEPTH];
    bit          known [2][DEPTH];
    bit          m_rb;
    logic [8:0]  m_addr;
    logic [7:0]  m_pal;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every valid output pixel is matched against the next expectation.
    always @(negedge CK) begin
        if (RD_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_rd_valid: got data %0h, expected no output", DATA_OUT);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) begin
                    checkOutput($sformatf("pixel_%0d", mon_e.pix), {20'd0, DATA_OUT}, {20'd0, mon_e.data});
                end
            end
        end
    end

    // Drive one cycle of inputs and advance the reference model to match.
    task automatic applyStimulus(input bit load, input logic [8:0] addr, input logic [7:0] pal,
                                 input bit we, input logic [3:0] idx, input bit flip, input bit start);
        exp_t e;
        LOAD = load; ADDR_LOAD = addr; SPR_PAL = pal;
        WE = we; COLOR_INDEX = idx; FLIP = flip; RD_START = start;
        if (load) begin
            m_addr = addr;
            m_pal  = pal;
        end else if (we) begin
            if (idx != 4'd0 && m_addr < DEPTH) begin
                mdl[m_rb][m_addr]   = pack_pixel(m_pal, idx);
                known[m_rb][m_addr] = 1'b1;
            end
            m_addr = m_addr + 9'd1;
        end
        if (flip) m_rb = ~m_rb;
        if (start) begin
            for (int i = 0; i < DEPTH; i++) begin
                e.chk  = known[~m_rb][i];
                e.data = mdl[~m_rb][i];
                e.pix  = 9'(i);
                exp_q.push_back(e);
            end
        end
        @(posedge CK);
        #1;
        LOAD = 0; ADDR_LOAD = '0; SPR_PAL = '0; WE = 0; COLOR_INDEX = '0; FLIP = 0; RD_START = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 0);
    endtask

    task automatic markCleared(input bit bank, input int count);
        for (int i = 0; i < count; i++) begin
            mdl[bank][i]   = 12'hFFF;
            known[bank][i] = 1'b1;
        end
    endtask

    // Count BUSY cycles of a stream just started, then expect a drained queue.
    task automatic waitStreamDone(input string tag);
        int cnt = 0;
        bit bank = ~m_rb;
        @(negedge CK);
        while (BUSY === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge CK);
        end
        checkOutput({tag, "_busy_cycles"}, cnt, 321);
        checkOutput({tag, "_queue_drained"}, exp_q.size(), 0);
        markCleared(bank, DEPTH);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        m_rb = 0; m_addr = '0; m_pal = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) begin
                known[b][i] = 1'b0;
                mdl[b][i]   = '0;
            end

        $display("[TB] reset");
        nRESET = 0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        checkOutput("reset_rd_valid", RD_VALID, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_data_out", DATA_OUT, 0);
        checkOutput("reset_render_bank", RENDER_BANK, 0);
`ifdef LINEBUFFER_OVF_FLAG_EN
        checkOutput("reset_ovf", OVF, 0);
`endif
        @(posedge CK);
        #1;
        nRESET = 1;

        $display("[TB] first stream of bank B, then a clean second stream");
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        waitStreamDone("stream1");
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        waitStreamDone("stream2");

        $display("[TB] clean bank A");
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        checkOutput("flip_render_bank_b", RENDER_BANK, 1);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        waitStreamDone("clean_a");
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);

        $display("[TB] sprite strip at 10 with transparent pixel");
        applyStimulus(1, 9'd10, 8'h35, 0, 4'd0, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h3, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h0, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h7, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'hF, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        waitStreamDone("strip10");

        $display("[TB] restream after two flips");
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        waitStreamDone("cleared");

        $display("[TB] strip running off the end of the line");
        applyStimulus(1, 9'd318, 8'hA2, 0, 4'd0, 0, 0);
        repeat (4) applyStimulus(0, 9'd0, 8'd0, 1, 4'h5, 0, 0);
`ifdef LINEBUFFER_OVF_FLAG_EN
        checkOutput("ovf_set", OVF, 1);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h6, 1, 0);
        checkOutput("ovf_set_beats_flip", OVF, 1);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        checkOutput("ovf_cleared_by_flip", OVF, 0);
`else
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
`endif
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        waitStreamDone("overflow");

        $display("[TB] FLIP during a stream");
        applyStimulus(1, 9'd100, 8'h12, 0, 4'd0, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h1, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h2, 0, 0);
        applyStimulus(1, 9'd200, 8'h77, 0, 4'd0, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h9, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        idle(100);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 0);
        @(negedge CK);
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_render_bank", RENDER_BANK, 0);
        checkOutput("abort_trailing_valid", RD_VALID, 1);
        @(negedge CK);
        checkOutput("abort_valid_drops", RD_VALID, 0);
        checkOutput("abort_pixels_delivered", DEPTH - exp_q.size(), 101);
        exp_q.delete();
        markCleared(1'b0, 101);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 1);
        waitStreamDone("retained");

        $display("[TB] LOAD with WE, then reset mid-stream");
        applyStimulus(1, 9'd50, 8'h44, 1, 4'h7, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 1, 4'h8, 0, 0);
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 1, 1);
        waitStreamDone("load_we");
        applyStimulus(0, 9'd0, 8'd0, 0, 4'd0, 0, 1);
        idle(20);
        nRESET = 0;
        @(posedge CK);
        #1;
        m_rb = 0; m_addr = '0; m_pal = '0;
        @(negedge CK);
        checkOutput("midreset_rd_valid", RD_VALID, 0);
        checkOutput("midreset_busy", BUSY, 0);
        checkOutput("midreset_render_bank", RENDER_BANK, 0);
        checkOutput("midreset_data_out", DATA_OUT, 0);
        checkOutput("midreset_pixels_delivered", DEPTH - exp_q.size(), 20);
`ifdef LINEBUFFER_OVF_FLAG_EN
        checkOutput("midreset_ovf", OVF, 0);
`endif
        exp_q.delete();
        @(posedge CK);
        #1;
        nRESET = 1;
        idle(3);
        checkOutput("post_reset_rd_valid", RD_VALID, 0);
        checkOutput("post_reset_busy", BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/linebuffer_pair.md
Name: linebuffer_pair

Overview:
- Parametrised double-buffered sprite line buffer.
- Two banks (A/B) of DEPTH pixels. While one bank is rendered into by the sprite pipeline, the other is streamed to the video output.
- Each streamed pixel is cleared to BACKDROP behind the read, so the bank is clean when it flips back to rendering.
- Sits between the sprite pixel/palette pipeline and the palette RAM address mux. Adds transparency skip, range checking and bank management over the single-bank buffer.

Parameters:
- DEPTH, 320: pixels per bank.
- AW, 9: address width; DEPTH <= 2**AW.
- IDX_W, 4: colour index width.
- PAL_W, 8: palette number width.
- BACKDROP, {(IDX_W+PAL_W){1'b1}}: value written on clear.

Ports:
- CK  in  1  system clock; all state updates on rising edge.
- nRESET  in  1  reset; synchronous, active-low.
- FLIP  in  1  one-cycle pulse: swap render/output banks at line boundary.
- LOAD  in  1  load render address from ADDR_LOAD and latch SPR_PAL.
- ADDR_LOAD  in  AW  start X position of the next sprite strip.
- SPR_PAL  in  PAL_W  palette for the strip; latched on LOAD.
- WE  in  1  pixel strobe; write COLOR_INDEX at the render address, then increment.
- COLOR_INDEX  in  IDX_W  pixel colour index; 0 = transparent.
- RD_START  in  1  start streaming the output bank from address 0.
- DATA_OUT  out  IDX_W+PAL_W  {palette, index} of the streamed pixel.
- RD_VALID  out  1  DATA_OUT valid this cycle.
- RENDER_BANK  out  1  0 = A is the render bank, 1 = B.
- BUSY  out  1  output stream in progress.

Behaviour:
- Reset (nRESET low at an edge):
  - RENDER_BANK=0, render address=0, palette latch=0.
  - Read FSM in IDLE; RD_VALID=0, BUSY=0, DATA_OUT=0.
  - RAM contents are not reset.
  - Reset asserted mid-stream aborts the stream; no further clears are performed.
- Render side, acting on bank RENDER_BANK:
  - LOAD: render address <= ADDR_LOAD; palette latch <= SPR_PAL.
  - WE with index != 0: write {pal, idx} at the render address; address +1.
  - WE with index == 0: no write; address still +1.
  - LOAD and WE in the same cycle: LOAD wins; WE is ignored.
  - Address >= DEPTH: the write is dropped and the increment continues. The address wraps at 2**AW with no effect on RAM.
- Read FSM, acting on bank ~RENDER_BANK:
  - States: IDLE, STREAM.
  - IDLE -> STREAM on RD_START; read address <= 0, BUSY=1.
  - In STREAM, each cycle: read addr, write BACKDROP to addr (same bank, read-before-write), addr +1.
  - Read latency 1: DATA_OUT/RD_VALID are registered one cycle after the address is issued.
  - After addr DEPTH-1 has been issued: STREAM -> IDLE; BUSY drops the next cycle.
  - Result: exactly DEPTH RD_VALID pulses per stream.
  - RD_START while in STREAM is ignored.
- FLIP:
  - RENDER_BANK toggles at the edge.
  - A write or LOAD in the same cycle targets the old render bank.
  - An active stream is aborted: FSM -> IDLE, BUSY=0, and RD_VALID drops after the in-flight pixel.
  - The unread remainder of the old output bank is not cleared.
- RD_START and FLIP in the same cycle: the stream starts on the new output bank (the old render bank).
- When idle, DATA_OUT holds its last value; consumers gate it with RD_VALID.

Optional Feature:
- Macro LINEBUFFER_OVF_FLAG_EN.
- Defined:
  - Adds output OVF (1 bit).
  - OVF sets sticky on any WE with index != 0 at address >= DEPTH.
  - OVF clears on FLIP or reset; if a set and FLIP coincide, set wins.
- Undefined: no OVF port and no logic. Out-of-range writes are silently dropped.

Decomposition:
- Package linebuffer_pkg:
  - Read FSM state enum (IDLE, STREAM).
  - Default DEPTH/AW/IDX_W/PAL_W constants.
  - Transparent index constant (0).
  - Helper to pack {pal, idx}.
- Sub-module lb_bank_ram: one bank, DEPTH x (IDX_W+PAL_W).
  - One write port plus one synchronous read port.
  - Read-before-write on an address collision.
  - Instantiated twice; port muxing by RENDER_BANK lives in the top.

Test Plan:
- Reset, then RD_START on bank B: 320 RD_VALID pulses, BUSY high 320+1 cycles. DATA_OUT value is don't-care the first time, then BACKDROP=12'hFFF on a second stream.
- LOAD addr 10, pal 8'h35; WE x4 with indices 3,0,7,F; FLIP; RD_START: pixels 10/12/13 = 12'h353/12'h357/12'h35F, pixel 11 = 12'hFFF.
- Same stream again after two FLIPs: all 320 pixels = 12'hFFF (clear-behind-read verified).
- LOAD addr 318; WE x4 index 5: only 318 and 319 written, addresses 320/321 dropped. OVF=1 with LINEBUFFER_OVF_FLAG_EN; OVF clears on FLIP.
- FLIP at pixel 100 of a stream: BUSY=0 next cycle, at most one trailing RD_VALID, RENDER_BANK toggled, pixels 101+ of the old bank retain data.
- LOAD+WE same cycle and nRESET low mid-stream: WE ignored (no write, address = ADDR_LOAD); after reset RD_VALID=0, RENDER_BANK=0.
